// File: rtl/result_vector_collector.sv
// Collects per-row dot-product results into a circular buffer and serves them
// first-word-fall-through to a consumer, tracking pass progress and drops.
module result_vector_collector #(
    parameter int element_width = 32,
    parameter int no_of_rows    = 256,
    parameter int addr_width    = 8
) (
    input  logic                     clk,
    input  logic                     main_reset_n,
    input  logic                     start,
    input  logic [element_width-1:0] adder_output,
    input  logic                     final_adder_finish_dash,
    input  logic                     rd_ready,
    output logic [element_width-1:0] rd_data,
    output logic                     rd_valid,
    output logic [addr_width:0]      rows_collected,
    output logic                     collect_done,
    output logic                     overflow_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [addr_width-1:0] last_addr  = addr_width'(no_of_rows - 1);
    localparam logic [addr_width-1:0] addr_one   = addr_width'(1);
    localparam logic [addr_width:0]   full_count = (addr_width + 1)'(no_of_rows);
    localparam logic [addr_width:0]   count_one  = (addr_width + 1)'(1);

    // Wrap explicitly so non-power-of-two depths also go last_addr -> 0.
    function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a);
        logic [addr_width-1:0] n;
        if (a == last_addr) begin
            n = '0;
        end else begin
            n = a + addr_one;
        end
        return n;
    endfunction

    logic [element_width-1:0] mem [no_of_rows];

    state_t                  state_r;
    logic [addr_width-1:0]   wr_ptr_r;
    logic [addr_width-1:0]   rd_ptr_r;
    logic [addr_width:0]     occupancy_r;
    logic [addr_width:0]     rows_collected_r;
    logic                    collect_done_r;
    logic                    overflow_err_r;

    logic                    rd_valid_s;
    logic                    rd_fire_s;
    logic                    full_s;
    logic                    sat_s;
    logic                    strobe_s;
    logic                    wr_accept_s;
    logic                    drop_s;
    logic [addr_width:0]     occupancy_next_s;
    logic [addr_width:0]     rows_next_s;
    logic                    done_next_s;
    logic                    overflow_next_s;
    logic [addr_width-1:0]   wr_ptr_next_s;
    logic [addr_width-1:0]   rd_ptr_next_s;
    state_t                  state_next_s;

    assign rd_valid_s = (occupancy_r != '0);

    // Next-state computation for pointers, occupancy, progress and error flags.
    always_comb begin
        rd_fire_s        = rd_valid_s && rd_ready;
        full_s           = (occupancy_r == full_count);
        sat_s            = (rows_collected_r == full_count);
        strobe_s         = start && final_adder_finish_dash;
        // A full buffer still takes a write when the same cycle frees a slot.
        wr_accept_s      = strobe_s && (!full_s || rd_fire_s);
        drop_s           = strobe_s && !wr_accept_s;
        occupancy_next_s = occupancy_r;
        rows_next_s      = rows_collected_r;
        wr_ptr_next_s    = wr_ptr_r;
        rd_ptr_next_s    = rd_ptr_r;
        state_next_s     = state_r;

        case ({wr_accept_s, rd_fire_s})
            2'b10:   occupancy_next_s = occupancy_r + count_one;
            2'b01:   occupancy_next_s = occupancy_r - count_one;
            default: occupancy_next_s = occupancy_r;
        endcase

        if (wr_accept_s) begin
            wr_ptr_next_s = next_addr(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (rd_fire_s) begin
            rd_ptr_next_s = next_addr(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        if (wr_accept_s && !sat_s) begin
            rows_next_s = rows_collected_r + count_one;
        end else begin
            rows_next_s = rows_collected_r;
        end

        done_next_s     = collect_done_r || (rows_next_s == full_count);
        // Writes beyond one full pass are stored but flagged.
        overflow_next_s = overflow_err_r || drop_s || (wr_accept_s && sat_s);

        case (state_r)
            ST_IDLE: begin
                if (done_next_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (done_next_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_DONE: state_next_s = ST_DONE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control FSM and all registered status; start low clears the pass.
    always_ff @(posedge clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state_r          <= ST_IDLE;
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            occupancy_r      <= '0;
            rows_collected_r <= '0;
            collect_done_r   <= 1'b0;
            overflow_err_r   <= 1'b0;
        end else if (!start) begin
            state_r          <= ST_IDLE;
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            occupancy_r      <= '0;
            rows_collected_r <= '0;
            collect_done_r   <= 1'b0;
            overflow_err_r   <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            wr_ptr_r         <= wr_ptr_next_s;
            rd_ptr_r         <= rd_ptr_next_s;
            occupancy_r      <= occupancy_next_s;
            rows_collected_r <= rows_next_s;
            collect_done_r   <= done_next_s;
            overflow_err_r   <= overflow_next_s;
        end
    end

    // Result storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem[wr_ptr_r] <= adder_output;
        end
    end

    assign rd_data        = mem[rd_ptr_r];
    assign rd_valid       = rd_valid_s;
    assign rows_collected = rows_collected_r;
    assign collect_done   = collect_done_r;
    assign overflow_err   = overflow_err_r;

endmodule

// File: tb/tb_result_vector_collector.sv
// Directed self-checking bench for result_vector_collector.
module tb_result_vector_collector;

    logic        clk;
    logic        main_reset_n;
    logic        start;
    logic [31:0] adder_output;
    logic        final_adder_finish_dash;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [8:0]  rows_collected;
    logic        collect_done;
    logic        overflow_err;

    int checks;
    int failures;

    result_vector_collector #(
        .element_width(32),
        .no_of_rows(256),
        .addr_width(8)
    ) dut (
        .clk(clk),
        .main_reset_n(main_reset_n),
        .start(start),
        .adder_output(adder_output),
        .final_adder_finish_dash(final_adder_finish_dash),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rows_collected(rows_collected),
        .collect_done(collect_done),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pass();
        final_adder_finish_dash = 1'b0;
        rd_ready = 1'b0;
        start = 1'b0;
        step();
        start = 1'b1;
    endtask

    task automatic test_reset();
        main_reset_n = 1'b0;
        start = 1'b0;
        final_adder_finish_dash = 1'b0;
        rd_ready = 1'b0;
        adder_output = 32'h0;
        step();
        step();
        checks++;
        if ({rd_valid, rows_collected, collect_done, overflow_err} !== {1'b0, 9'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got v=%b rows=%0d done=%b ovf=%b want 0/0/0/0",
                     rd_valid, rows_collected, collect_done, overflow_err);
        end
        main_reset_n = 1'b1;
        step();
        start = 1'b1;
    endtask

    task automatic test_three();
        logic [31:0] vals [3];
        vals[0] = 32'h3F80_0000;
        vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000;
        for (int i = 0; i < 3; i++) begin
            adder_output = vals[i];
            final_adder_finish_dash = 1'b1;
            step();
        end
        final_adder_finish_dash = 1'b0;
        checks++;
        if ({rows_collected, rd_valid} !== {9'd3, 1'b1} || rd_data !== 32'h3F80_0000) begin
            failures++;
            $display("FAIL three_fill got rows=%0d v=%b data=%h want 3/1/3f800000",
                     rows_collected, rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
                failures++;
                $display("FAIL three_read%0d got v=%b data=%h want 1/%h", i, rd_valid, rd_data, vals[i]);
            end
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rows_collected !== 9'd3) begin
            failures++;
            $display("FAIL three_empty got v=%b rows=%0d want 0/3", rd_valid, rows_collected);
        end
    endtask

    task automatic test_fill_and_full();
        int k;
        logic [31:0] exp_v;
        new_pass();
        for (int i = 1; i <= 256; i++) begin
            adder_output = 32'(i);
            final_adder_finish_dash = 1'b1;
            step();
            if (i == 255) begin
                checks++;
                if (collect_done !== 1'b0) begin
                    failures++;
                    $display("FAIL done_early got %b want 0", collect_done);
                end
            end
        end
        checks++;
        if ({collect_done, overflow_err, rows_collected} !== {1'b1, 1'b0, 9'd256}) begin
            failures++;
            $display("FAIL fill_256 got done=%b ovf=%b rows=%0d want 1/0/256",
                     collect_done, overflow_err, rows_collected);
        end
        adder_output = 32'd999;
        step();
        checks++;
        if ({overflow_err, rows_collected} !== {1'b1, 9'd256} || rd_data !== 32'd1) begin
            failures++;
            $display("FAIL drop_257 got ovf=%b rows=%0d data=%0d want 1/256/1",
                     overflow_err, rows_collected, rd_data);
        end
        adder_output = 32'h0000_00AA;
        rd_ready = 1'b1;
        checks++;
        if (rd_data !== 32'd1) begin
            failures++;
            $display("FAIL full_rw_read got %0d want 1", rd_data);
        end
        step();
        final_adder_finish_dash = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd2) begin
            failures++;
            $display("FAIL full_rw_next got v=%b data=%0d want 1/2", rd_valid, rd_data);
        end
        k = 0;
        while (rd_valid && k < 300) begin
            exp_v = (k < 255) ? 32'(k + 2) : 32'h0000_00AA;
            checks++;
            if (rd_data !== exp_v) begin
                failures++;
                $display("FAIL drain_%0d got %h want %h", k, rd_data, exp_v);
            end
            step();
            k++;
        end
        rd_ready = 1'b0;
        checks++;
        if (k !== 256) begin
            failures++;
            $display("FAIL drain_count got %0d want 256", k);
        end
    endtask

    task automatic test_stream();
        logic [8:0] exp_rows;
        logic       exp_ovf;
        new_pass();
        for (int i = 0; i < 600; i++) begin
            adder_output = 32'h0001_0000 + 32'(i);
            final_adder_finish_dash = 1'b1;
            rd_ready = 1'b1;
            if (i > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 32'h0001_0000 + 32'(i - 1)) begin
                    failures++;
                    $display("FAIL stream_data%0d got v=%b data=%h want 1/%h",
                             i, rd_valid, rd_data, 32'h0001_0000 + 32'(i - 1));
                end
            end
            step();
            exp_rows = (i + 1 >= 256) ? 9'd256 : 9'(i + 1);
            exp_ovf  = (i + 1 >= 257);
            checks++;
            if (rows_collected !== exp_rows || overflow_err !== exp_ovf) begin
                failures++;
                $display("FAIL stream_stat%0d got rows=%0d ovf=%b want %0d/%b",
                         i, rows_collected, overflow_err, exp_rows, exp_ovf);
            end
        end
        final_adder_finish_dash = 1'b0;
        checks++;
        if (rd_data !== 32'h0001_0257) begin
            failures++;
            $display("FAIL stream_last got %h want 00010257", rd_data);
        end
        step();
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_empty got v=%b want 0", rd_valid);
        end
    endtask

    task automatic test_async_reset();
        new_pass();
        for (int i = 0; i < 10; i++) begin
            adder_output = 32'h100 + 32'(i);
            final_adder_finish_dash = 1'b1;
            step();
        end
        final_adder_finish_dash = 1'b0;
        #1;
        main_reset_n = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rows_collected, collect_done, overflow_err} !== {1'b0, 9'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got v=%b rows=%0d done=%b ovf=%b want 0/0/0/0",
                     rd_valid, rows_collected, collect_done, overflow_err);
        end
        #1;
        main_reset_n = 1'b1;
        adder_output = 32'h55;
        final_adder_finish_dash = 1'b1;
        step();
        final_adder_finish_dash = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h55 || rows_collected !== 9'd1) begin
            failures++;
            $display("FAIL after_reset got v=%b data=%h rows=%0d want 1/55/1",
                     rd_valid, rd_data, rows_collected);
        end
    endtask

    task automatic test_start_drop();
        adder_output = 32'h66;
        final_adder_finish_dash = 1'b1;
        step();
        adder_output = 32'h77;
        start = 1'b0;
        step();
        checks++;
        if ({rows_collected, rd_valid, overflow_err, collect_done} !== {9'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL start_low got rows=%0d v=%b ovf=%b done=%b want 0/0/0/0",
                     rows_collected, rd_valid, overflow_err, collect_done);
        end
        start = 1'b1;
        final_adder_finish_dash = 1'b0;
        rd_ready = 1'b1;
        step();
        checks++;
        if (rows_collected !== 9'd0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_read got rows=%0d v=%b want 0/0", rows_collected, rd_valid);
        end
        rd_ready = 1'b0;
        adder_output = 32'h88;
        final_adder_finish_dash = 1'b1;
        step();
        final_adder_finish_dash = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h88 || rows_collected !== 9'd1) begin
            failures++;
            $display("FAIL resume got v=%b data=%h rows=%0d want 1/88/1",
                     rd_valid, rd_data, rows_collected);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_three();
        test_fill_and_full();
        test_stream();
        test_async_reset();
        test_start_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
